// File: rtl/bfp_pkg.sv
// Shared sizing defaults, FSM state type and term-width helper for the
// block-floating-point dot-product accumulator.
package bfp_pkg;

    localparam int unsigned MANT_W = 11;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Signed width able to hold the sum of LANES signed products.
    function automatic int unsigned term_w(input int unsigned mant_w);
        return 2 * mant_w + 3;
    endfunction

endpackage

// File: rtl/bfp_dot_accumulator_if.sv
// Input block-pair stream and group-result stream of the BFP dot accumulator.
interface bfp_dot_accumulator_if #(
    parameter int unsigned MANT_W = bfp_pkg::MANT_W,
    parameter int unsigned EXP_W  = bfp_pkg::EXP_W,
    parameter int unsigned ACC_W  = bfp_pkg::ACC_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [MANT_W-1:0]        a_m0;
    logic [MANT_W-1:0]        a_m1;
    logic [MANT_W-1:0]        a_m2;
    logic [MANT_W-1:0]        a_m3;
    logic [3:0]               a_s;
    logic [EXP_W-1:0]         a_exp;
    logic [MANT_W-1:0]        b_m0;
    logic [MANT_W-1:0]        b_m1;
    logic [MANT_W-1:0]        b_m2;
    logic [MANT_W-1:0]        b_m3;
    logic [3:0]               b_s;
    logic [EXP_W-1:0]         b_exp;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic [EXP_W:0]           out_exp;
    logic                     out_ovf;

    modport master (
        output in_valid, in_last,
        output a_m0, a_m1, a_m2, a_m3, a_s, a_exp,
        output b_m0, b_m1, b_m2, b_m3, b_s, b_exp,
        output out_ready,
        input  in_ready, out_valid, out_acc, out_exp, out_ovf
    );

    modport slave (
        input  in_valid, in_last,
        input  a_m0, a_m1, a_m2, a_m3, a_s, a_exp,
        input  b_m0, b_m1, b_m2, b_m3, b_s, b_exp,
        input  out_ready,
        output in_ready, out_valid, out_acc, out_exp, out_ovf
    );

endinterface

// File: rtl/bfp_align_add.sv
// Combinational exponent alignment, accumulate and saturation of one term
// into the running block-floating-point accumulator.
module bfp_align_add #(
    parameter int unsigned ACC_W = bfp_pkg::ACC_W,
    parameter int unsigned T_W   = bfp_pkg::term_w(bfp_pkg::MANT_W),
    parameter int unsigned E_W   = bfp_pkg::EXP_W + 1
) (
    input  logic                    first_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic [E_W-1:0]          acc_exp_i,
    input  logic signed [T_W-1:0]   t_i,
    input  logic [E_W-1:0]          e_i,
    output logic signed [ACC_W-1:0] acc_c_o,
    output logic [E_W-1:0]          exp_c_o,
    output logic                    sat_c_o
);

    // Arithmetic right shift where distances past the width collapse to sign fill.
    function automatic logic signed [ACC_W-1:0] sra_sat(
        input logic signed [ACC_W-1:0] v,
        input logic [E_W-1:0]          sh
    );
        if (32'(sh) >= ACC_W) begin
            return {ACC_W{v[ACC_W-1]}};
        end
        return v >>> sh;
    endfunction

    logic signed [ACC_W-1:0] t_ext;
    logic signed [ACC_W-1:0] add_a;
    logic signed [ACC_W-1:0] add_b;
    logic signed [ACC_W:0]   sum;

    always_comb begin
        t_ext   = {{(ACC_W-T_W){t_i[T_W-1]}}, t_i};
        add_a   = '0;
        add_b   = '0;
        sum     = '0;
        acc_c_o = acc_i;
        exp_c_o = acc_exp_i;
        sat_c_o = 1'b0;
        if (first_i) begin
            acc_c_o = t_ext;
            exp_c_o = e_i;
        end else begin
            if (e_i >= acc_exp_i) begin
                add_a   = sra_sat(acc_i, e_i - acc_exp_i);
                add_b   = t_ext;
                exp_c_o = e_i;
            end else begin
                add_a = acc_i;
                add_b = sra_sat(t_ext, acc_exp_i - e_i);
            end
            sum = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
            // Top two sum bits disagree only when the true sum left the ACC_W range.
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                sat_c_o = 1'b1;
                acc_c_o = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_c_o = sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bfp_dot_accumulator.sv
// Four-lane block-floating-point dot product with a saturating, exponent-
// aligning group accumulator: multiply, reduce, accumulate, then present.
module bfp_dot_accumulator #(
    parameter int unsigned MANT_W = bfp_pkg::MANT_W,
    parameter int unsigned EXP_W  = bfp_pkg::EXP_W,
    parameter int unsigned ACC_W  = bfp_pkg::ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    bfp_dot_accumulator_if.slave bus
);

    import bfp_pkg::*;

    localparam int unsigned P_W = 2 * MANT_W;
    localparam int unsigned T_W = term_w(MANT_W);
    localparam int unsigned E_W = EXP_W + 1;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   out_load_c, out_clear_c;
    logic   accept_c;

    logic [LANES-1:0][MANT_W-1:0] a_m_c;
    logic [LANES-1:0][MANT_W-1:0] b_m_c;

    logic                      s1_valid_q, s1_last_q;
    logic [LANES-1:0][P_W-1:0] s1_prod_q;
    logic [LANES-1:0]          s1_sgn_q;
    logic [E_W-1:0]            s1_exp_q;

    logic                    s2_valid_q, s2_last_q;
    logic signed [T_W-1:0]   s2_t_q;
    logic [E_W-1:0]          s2_exp_q;
    logic signed [T_W-1:0]   t_sum_c;

    logic signed [ACC_W-1:0] acc_q;
    logic [E_W-1:0]          acc_exp_q;
    logic                    acc_first_q;
    logic                    grp_ovf_q;
    logic                    s3_last_q;
    logic signed [ACC_W-1:0] acc_c;
    logic [E_W-1:0]          acc_exp_c;
    logic                    sat_c;

    logic signed [ACC_W-1:0] out_acc_q;
    logic [E_W-1:0]          out_exp_q;
    logic                    out_ovf_q;

    assign a_m_c    = {bus.a_m3, bus.a_m2, bus.a_m1, bus.a_m0};
    assign b_m_c    = {bus.b_m3, bus.b_m2, bus.b_m1, bus.b_m0};
    assign accept_c = bus.in_valid && in_ready_q;

    // Stage 1: lane products, product signs and summed block exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            s1_sgn_q   <= '0;
            s1_exp_q   <= '0;
        end else begin
            s1_valid_q <= accept_c;
            s1_last_q  <= accept_c && bus.in_last;
            if (accept_c) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_prod_q[i] <= P_W'(a_m_c[i]) * P_W'(b_m_c[i]);
                end
                s1_sgn_q <= bus.a_s ^ bus.b_s;
                s1_exp_q <= E_W'(bus.a_exp) + E_W'(bus.b_exp);
            end
        end
    end

    always_comb begin
        t_sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_sgn_q[i]) begin
                t_sum_c = t_sum_c - $signed(T_W'(s1_prod_q[i]));
            end else begin
                t_sum_c = t_sum_c + $signed(T_W'(s1_prod_q[i]));
            end
        end
    end

    // Stage 2: signed reduction of the four lanes into one term.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_t_q     <= '0;
            s2_exp_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                s2_t_q   <= t_sum_c;
                s2_exp_q <= s1_exp_q;
            end
        end
    end

    bfp_align_add #(
        .ACC_W (ACC_W),
        .T_W   (T_W),
        .E_W   (E_W)
    ) u_align_add (
        .first_i   (acc_first_q),
        .acc_i     (acc_q),
        .acc_exp_i (acc_exp_q),
        .t_i       (s2_t_q),
        .e_i       (s2_exp_q),
        .acc_c_o   (acc_c),
        .exp_c_o   (acc_exp_c),
        .sat_c_o   (sat_c)
    );

    // Stage 3: accumulator; the last term re-arms the first-term flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_exp_q   <= '0;
            acc_first_q <= 1'b1;
            grp_ovf_q   <= 1'b0;
            s3_last_q   <= 1'b0;
        end else begin
            s3_last_q <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                acc_q       <= acc_c;
                acc_exp_q   <= acc_exp_c;
                acc_first_q <= s2_last_q;
                grp_ovf_q   <= (grp_ovf_q && !acc_first_q) || sat_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_load_c  = 1'b0;
        out_clear_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = bus.in_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept_c && bus.in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s3_last_q) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_load_c  = 1'b1;
                end
            end
            ST_OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_clear_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    end

    // Result holding register; reads as zero whenever no result is offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_acc_q <= '0;
            out_exp_q <= '0;
            out_ovf_q <= 1'b0;
        end else if (out_load_c) begin
            out_acc_q <= acc_q;
            out_exp_q <= acc_exp_q;
            out_ovf_q <= grp_ovf_q;
        end else if (out_clear_c) begin
            out_acc_q <= '0;
            out_exp_q <= '0;
            out_ovf_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bfp_dot_accumulator.sv
// Directed and randomized checks of bfp_dot_accumulator against an
// arithmetic reference model of the group accumulation rules.
module tb_bfp_dot_accumulator;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct packed {
        logic [3:0][10:0] am;
        logic [3:0][10:0] bm;
        logic [3:0]       sa;
        logic [3:0]       sb;
        logic [4:0]       ea;
        logic [4:0]       eb;
    } beat_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    longint obs_acc;
    longint obs_exp;
    longint obs_ovf;

    bfp_dot_accumulator_if ifc ();

    bfp_dot_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Floor division by 2^k; huge distances leave only the sign.
    function automatic longint floor_pow2(input longint v, input int k);
        longint d;
        longint q;
        if (k >= 32) return (v < 0) ? -64'sd1 : 64'sd0;
        d = 64'sd1 << k;
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q;
    endfunction

    function automatic void model_group(input beat_t q[$], output longint acc,
                                        output longint ex, output longint ovf);
        acc = 0;
        ex  = 0;
        ovf = 0;
        foreach (q[k]) begin
            longint t;
            longint e;
            longint s;
            t = 0;
            for (int i = 0; i < 4; i++) begin
                longint p;
                p = longint'(q[k].am[i]) * longint'(q[k].bm[i]);
                t = (q[k].sa[i] ^ q[k].sb[i]) ? t - p : t + p;
            end
            e = longint'(q[k].ea) + longint'(q[k].eb);
            if (k == 0) begin
                acc = t;
                ex  = e;
            end else begin
                if (e >= ex) begin
                    s  = floor_pow2(acc, int'(e - ex)) + t;
                    ex = e;
                end else begin
                    s = acc + floor_pow2(t, int'(ex - e));
                end
                if (s > MAXV) begin s = MAXV; ovf = 1; end
                if (s < MINV) begin s = MINV; ovf = 1; end
                acc = s;
            end
        end
    endfunction

    function automatic beat_t mk_beat(input logic [10:0] m, input logic [3:0] sa,
                                      input logic [4:0] ea, input logic [4:0] eb);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.am[i] = m;
            b.bm[i] = m;
        end
        b.sa = sa;
        b.sb = 4'b0000;
        b.ea = ea;
        b.eb = eb;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.am[i] = 11'($urandom_range(0, 2047));
            b.bm[i] = 11'($urandom_range(0, 2047));
        end
        b.sa = 4'($urandom_range(0, 15));
        b.sb = 4'($urandom_range(0, 15));
        b.ea = 5'($urandom_range(0, 31));
        b.eb = 5'($urandom_range(0, 31));
        return b;
    endfunction

    // Entered and left at a falling edge; acceptance happens on the rising edge between.
    task automatic put_beat(input beat_t b, input bit last);
        int guard;
        guard = 0;
        ifc.in_valid = 1'b1;
        ifc.in_last  = last;
        ifc.a_m0 = b.am[0]; ifc.a_m1 = b.am[1]; ifc.a_m2 = b.am[2]; ifc.a_m3 = b.am[3];
        ifc.b_m0 = b.bm[0]; ifc.b_m1 = b.bm[1]; ifc.b_m2 = b.bm[2]; ifc.b_m3 = b.bm[3];
        ifc.a_s = b.sa; ifc.b_s = b.sb; ifc.a_exp = b.ea; ifc.b_exp = b.eb;
        while (ifc.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_beat", longint'(ifc.in_ready), 1);
        @(negedge clk);
    endtask

    task automatic run_group(input beat_t q[$], input int stall, input string tag);
        longint eacc;
        longint eexp;
        longint eovf;
        int     edges;
        model_group(q, eacc, eexp, eovf);
        foreach (q[k]) put_beat(q[k], k == q.size() - 1);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        edges = 1;
        while (ifc.out_valid !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, 4);
        obs_acc = longint'(ifc.out_acc);
        obs_exp = longint'(ifc.out_exp);
        obs_ovf = longint'(ifc.out_ovf);
        check({tag, "_acc"}, obs_acc, eacc);
        check({tag, "_exp"}, obs_exp, eexp);
        check({tag, "_ovf"}, obs_ovf, eovf);
        check({tag, "_in_ready_out"}, longint'(ifc.in_ready), 0);
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, longint'(ifc.out_valid), 1);
            check({tag, "_hold_acc"}, longint'(ifc.out_acc), eacc);
            check({tag, "_hold_exp"}, longint'(ifc.out_exp), eexp);
            check({tag, "_hold_ovf"}, longint'(ifc.out_ovf), eovf);
            check({tag, "_hold_in_ready"}, longint'(ifc.in_ready), 0);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check({tag, "_post_valid"}, longint'(ifc.out_valid), 0);
        check({tag, "_post_acc_zero"}, longint'(ifc.out_acc), 0);
        check({tag, "_post_in_ready"}, longint'(ifc.in_ready), 1);
    endtask

    initial begin
        beat_t q[$];
        beat_t base;

        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_last = 1'b0; ifc.out_ready = 1'b0;
        ifc.a_m0 = '0; ifc.a_m1 = '0; ifc.a_m2 = '0; ifc.a_m3 = '0;
        ifc.b_m0 = '0; ifc.b_m1 = '0; ifc.b_m2 = '0; ifc.b_m3 = '0;
        ifc.a_s = '0; ifc.b_s = '0; ifc.a_exp = '0; ifc.b_exp = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(ifc.in_ready), 0);
        check("rst_out_valid", longint'(ifc.out_valid), 0);
        check("rst_out_acc", longint'(ifc.out_acc), 0);
        check("rst_out_exp", longint'(ifc.out_exp), 0);
        check("rst_out_ovf", longint'(ifc.out_ovf), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(ifc.in_ready), 1);

        base = mk_beat(11'd1024, 4'b0000, 5'd15, 5'd15);

        q = {};
        q.push_back(base);
        run_group(q, 0, "single");
        check("single_const_acc", obs_acc, 4194304);
        check("single_const_exp", obs_exp, 30);
        check("single_const_ovf", obs_ovf, 0);

        q = {};
        q.push_back(mk_beat(11'd1024, 4'b0101, 5'd15, 5'd15));
        run_group(q, 0, "signs");
        check("signs_const_acc", obs_acc, 0);
        check("signs_const_exp", obs_exp, 30);

        q = {};
        q.push_back(base);
        q.push_back(mk_beat(11'd1024, 4'b0000, 5'd16, 5'd16));
        run_group(q, 0, "two_beat");
        check("two_beat_const_acc", obs_acc, 5242880);
        check("two_beat_const_exp", obs_exp, 32);

        q = {};
        q.push_back(base);
        run_group(q, 5, "backpressure");
        check("backpressure_const_acc", obs_acc, 4194304);
        q = {};
        q.push_back(mk_beat(11'd512, 4'b0011, 5'd3, 5'd9));
        run_group(q, 0, "after_handshake");

        put_beat(rnd_beat(), 1'b0);
        put_beat(rnd_beat(), 1'b0);
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_in_ready", longint'(ifc.in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        q = {};
        q.push_back(base);
        run_group(q, 0, "after_abort");
        check("after_abort_const_acc", obs_acc, 4194304);

        q = {};
        for (int k = 0; k < 200; k++) q.push_back(mk_beat(11'd2047, 4'b0000, 5'd15, 5'd15));
        run_group(q, 0, "saturate");
        check("saturate_const_acc", obs_acc, 2147483647);
        check("saturate_const_ovf", obs_ovf, 1);

        q = {};
        for (int k = 0; k < 200; k++) q.push_back(mk_beat(11'd2047, 4'b1111, 5'd15, 5'd15));
        run_group(q, 1, "saturate_neg");

        q = {};
        q.push_back(base);
        run_group(q, 0, "ovf_cleared");
        check("ovf_cleared_const_ovf", obs_ovf, 0);

        for (int g = 0; g < 12; g++) begin
            int n;
            n = $urandom_range(1, 6);
            q = {};
            for (int k = 0; k < n; k++) q.push_back(rnd_beat());
            run_group(q, $urandom_range(0, 3), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
